control_unit: RTL and testbench

//  Multi-cycle sequencer for the HRM CPU datapath. Owns the PC and instruction register and steps

---
 rtl/control_unit.sv | 171 +++++++++++++++++
 tb/tb_control_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the HRM CPU: owns PC and IR and
// steers R, data memory, ALU and the inbox/outbox handshakes.
module control_unit #(
   parameter int PC_W   = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        iProg,
   input  logic [7:0]        iR,
   input  logic              iInEmpty,
   input  logic              iOutFull,
   output logic [PC_W-1:0]   oPC,
   output logic [ADDR_W-1:0] oAddr,
   output logic [1:0]        muxR,
   output logic              wR,
   output logic              wM,
   output logic              muxM,
   output logic [1:0]        aluOp,
   output logic              oInPop,
   output logic              oOutPush,
   output logic              oHalt,
   output logic              oIllegal
);

   localparam logic [3:0] OP_INBOX    = 4'h0;
   localparam logic [3:0] OP_OUTBOX   = 4'h1;
   localparam logic [3:0] OP_COPYFROM = 4'h2;
   localparam logic [3:0] OP_COPYTO   = 4'h3;
   localparam logic [3:0] OP_ADD      = 4'h4;
   localparam logic [3:0] OP_SUB      = 4'h5;
   localparam logic [3:0] OP_BUMPUP   = 4'h6;
   localparam logic [3:0] OP_BUMPDN   = 4'h7;
   localparam logic [3:0] OP_JUMP     = 4'h8;
   localparam logic [3:0] OP_JUMPZ    = 4'h9;
   localparam logic [3:0] OP_JUMPN    = 4'hA;

   typedef enum logic [2:0] {
      FETCH, DECODE, FETCH_OP, LOAD_OP, EXEC, MEMRD, HALTED
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_pc;
   logic [3:0]      r_ir;
   logic [7:0]      r_op;
   logic            r_illegal;
   logic            w_hasOperand;
   logic            w_illegalOp;
   logic [PC_W-1:0] w_target;

   // Only the opcode nibble of the instruction is ever consulted after DECODE.
   assign w_hasOperand = (iProg[7:4] >= OP_COPYFROM) && (iProg[7:4] <= OP_JUMPN);
   assign w_illegalOp  = (r_ir >= 4'hB) && (r_ir <= 4'hE);
   assign w_target     = PC_W'(r_op);
   assign oPC          = r_pc;
   assign oAddr        = r_op[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= '0;
         r_ir      <= '0;
         r_op      <= '0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            DECODE: begin
               r_ir <= iProg[7:4];
               r_pc <= r_pc + PC_W'(1);
            end
            LOAD_OP: begin
               r_op <= iProg;
               r_pc <= r_pc + PC_W'(1);
            end
            EXEC: begin
               if (r_ir == OP_JUMP) r_pc <= w_target;
               if (r_ir == OP_JUMPZ && iR == 8'd0) r_pc <= w_target;
               if (r_ir == OP_JUMPN && iR[7]) r_pc <= w_target;
               if (w_illegalOp) r_illegal <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // INBOX/OUTBOX simply hold in EXEC while their FIFO is not ready.
   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:    w_next = DECODE;
         DECODE:   w_next = w_hasOperand ? FETCH_OP : EXEC;
         FETCH_OP: w_next = LOAD_OP;
         LOAD_OP:  w_next = EXEC;
         EXEC: begin
            case (r_ir)
               OP_INBOX:  w_next = iInEmpty ? EXEC : FETCH;
               OP_OUTBOX: w_next = iOutFull ? EXEC : FETCH;
               OP_COPYTO, OP_JUMP, OP_JUMPZ, OP_JUMPN: w_next = FETCH;
               OP_COPYFROM, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: w_next = MEMRD;
               default:   w_next = HALTED;
            endcase
         end
         MEMRD:    w_next = FETCH;
         HALTED:   w_next = HALTED;
         default:  w_next = FETCH;
      endcase
   end

   // Outputs are forced quiet while rst is high so a pending pop/push never fires.
   always_comb begin
      muxR     = 2'b00;
      wR       = 1'b0;
      wM       = 1'b0;
      muxM     = 1'b0;
      aluOp    = 2'b00;
      oInPop   = 1'b0;
      oOutPush = 1'b0;
      oHalt    = 1'b0;
      oIllegal = 1'b0;
      if (!rst) begin
         case (r_state)
            EXEC: begin
               if (r_ir == OP_INBOX && !iInEmpty) begin
                  oInPop = 1'b1;
                  wR     = 1'b1;
               end
               if (r_ir == OP_OUTBOX && !iOutFull) oOutPush = 1'b1;
               if (r_ir == OP_COPYTO) wM = 1'b1;
            end
            MEMRD: begin
               wR = 1'b1;
               case (r_ir)
                  OP_COPYFROM: muxR = 2'b01;
                  OP_ADD: begin
                     muxR  = 2'b11;
                     aluOp = 2'b00;
                  end
                  OP_SUB: begin
                     muxR  = 2'b11;
                     aluOp = 2'b01;
                  end
                  OP_BUMPUP: begin
                     muxR  = 2'b11;
                     wM    = 1'b1;
                     muxM  = 1'b1;
                     aluOp = 2'b10;
                  end
                  OP_BUMPDN: begin
                     muxR  = 2'b11;
                     wM    = 1'b1;
                     muxM  = 1'b1;
                     aluOp = 2'b11;
                  end
                  default: wR = 1'b0;
               endcase
            end
            HALTED: begin
               oHalt    = 1'b1;
               oIllegal = r_illegal;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model expands each program into the
// expected per-cycle output trace, which is compared against the DUT every cycle.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] iProg;
   logic [7:0] iR;
   logic       iInEmpty;
   logic       iOutFull;
   logic [7:0] oPC;
   logic [7:0] oAddr;
   logic [1:0] muxR;
   logic       wR;
   logic       wM;
   logic       muxM;
   logic [1:0] aluOp;
   logic       oInPop;
   logic       oOutPush;
   logic       oHalt;
   logic       oIllegal;

   always #5 clk = ~clk;

   control_unit #(.PC_W(8), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst), .iProg(iProg), .iR(iR),
      .iInEmpty(iInEmpty), .iOutFull(iOutFull),
      .oPC(oPC), .oAddr(oAddr), .muxR(muxR), .wR(wR), .wM(wM), .muxM(muxM),
      .aluOp(aluOp), .oInPop(oInPop), .oOutPush(oOutPush),
      .oHalt(oHalt), .oIllegal(oIllegal)
   );

   // Program ROM with one cycle of read latency.
   logic [7:0] rom [256];
   always @(posedge clk) iProg <= rom[oPC];

   wire [26:0] dutVec = {oPC, oAddr, muxR, wR, wM, muxM, aluOp, oInPop, oOutPush, oHalt, oIllegal};

   logic [26:0] expQ[$];
   int          compared   = 0;
   int          mismatched = 0;
   logic [7:0]  mPc;
   logic [7:0]  mAddr;
   logic [7:0]  regR;
   int          emptyUntil;
   int          fullUntil;
   int          popCycle;
   int          haltCycle;
   int          pushCount;
   int          wRCount;
   int          wMCount;
   int          probeA;
   int          probeB;
   logic [7:0]  pcA;
   logic [7:0]  pcB;
   logic [26:0] vecA;

   function automatic logic [26:0] pack(input logic [7:0] pc, input logic [7:0] addr,
                                        input logic [1:0] mr, input logic r, input logic m,
                                        input logic mm, input logic [1:0] alu, input logic pop,
                                        input logic push, input logic halt, input logic ill);
      return {pc, addr, mr, r, m, mm, alu, pop, push, halt, ill};
   endfunction

   task automatic emit(input logic [1:0] mr, input logic r, input logic m, input logic mm,
                       input logic [1:0] alu, input logic pop, input logic push);
      expQ.push_back(pack(mPc, mAddr, mr, r, m, mm, alu, pop, push, 1'b0, 1'b0));
   endtask

   task automatic emitQuiet();
      emit(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   // Walks the program instruction by instruction from address 0 until it halts.
   task automatic buildModel();
      logic [3:0] op;
      logic [7:0] operand;
      bit         done;
      expQ.delete();
      mPc     = 8'h00;
      mAddr   = 8'h00;
      operand = 8'h00;
      done    = 1'b0;
      while (!done && expQ.size() < 300) begin
         op = rom[mPc][7:4];
         emitQuiet();
         emitQuiet();
         mPc = mPc + 8'd1;
         if (op >= 4'h2 && op <= 4'hA) begin
            emitQuiet();
            emitQuiet();
            operand = rom[mPc];
            mPc     = mPc + 8'd1;
            mAddr   = operand;
         end
         case (op)
            4'h0: begin
               while (expQ.size() < emptyUntil) emitQuiet();
               emit(2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            end
            4'h1: begin
               while (expQ.size() < fullUntil) emitQuiet();
               emit(2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
            end
            4'h3: emit(2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
            4'h8: begin emitQuiet(); mPc = operand; end
            4'h9: begin emitQuiet(); if (regR == 8'd0) mPc = operand; end
            4'hA: begin emitQuiet(); if (regR[7]) mPc = operand; end
            4'h2: begin emitQuiet(); emit(2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0); end
            4'h4: begin emitQuiet(); emit(2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0); end
            4'h5: begin emitQuiet(); emit(2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0); end
            4'h6: begin emitQuiet(); emit(2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0); end
            4'h7: begin emitQuiet(); emit(2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0); end
            default: begin
               emitQuiet();
               repeat (3) expQ.push_back(pack(mPc, mAddr, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00,
                                              1'b0, 1'b0, 1'b1, op != 4'hF));
               done = 1'b1;
            end
         endcase
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
   endtask

   task automatic doReset();
      rst      = 1'b1;
      iInEmpty = 1'b0;
      iOutFull = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Resets the DUT, then runs the model trace cycle by cycle while recording events.
   task automatic applyStimulus(input string name);
      popCycle  = -1;
      haltCycle = -1;
      pushCount = 0;
      wRCount   = 0;
      wMCount   = 0;
      pcA       = 8'hXX;
      pcB       = 8'hXX;
      vecA      = 'x;
      iR        = regR;
      buildModel();
      doReset();
      for (int k = 0; k < expQ.size(); k++) begin
         iInEmpty = (k < emptyUntil);
         iOutFull = (k < fullUntil);
         #4;
         checkOutput($sformatf("%s cyc%0d", name, k), {5'd0, dutVec}, {5'd0, expQ[k]});
         if (oInPop && popCycle < 0) popCycle = k;
         if (oHalt && haltCycle < 0) haltCycle = k;
         pushCount += int'(oOutPush);
         wRCount   += int'(wR);
         wMCount   += int'(wM);
         if (k == probeA) begin pcA = oPC; vecA = dutVec; end
         if (k == probeB) pcB = oPC;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setupTest(input logic [7:0] r, input int eu, input int fu, input int pa, input int pb);
      clearRom();
      regR       = r;
      emptyUntil = eu;
      fullUntil  = fu;
      probeA     = pa;
      probeB     = pb;
   endtask

   initial begin
      clearRom();
      rst = 1'b1;
      iR  = 8'h00;
      iInEmpty = 1'b0;
      iOutFull = 1'b0;
      @(posedge clk);
      #4 checkOutput("reset state", {5'd0, dutVec}, 32'd0);

      // INBOX, OUTBOX, HALT with a ready inbox.
      setupTest(8'h05, 0, 0, 2, -1);
      rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'hF0;
      applyStimulus("io_halt");
      checkOutput("io_halt pop cycle", popCycle, 2);
      checkOutput("io_halt push count", pushCount, 1);
      checkOutput("io_halt halt cycle", haltCycle, 9);
      checkOutput("io_halt halted pc", oPC, 8'h03);

      // INBOX stalled on an empty FIFO for four EXEC cycles.
      setupTest(8'h00, 6, 0, -1, -1);
      rom[0] = 8'h00; rom[1] = 8'hF0;
      applyStimulus("inbox_stall");
      checkOutput("inbox_stall pop cycle", popCycle, 6);
      checkOutput("inbox_stall wR count", wRCount, 1);

      // JUMPZ taken when R is zero.
      setupTest(8'h00, 0, 0, 5, -1);
      rom[0] = 8'h90; rom[1] = 8'h10;
      applyStimulus("jumpz_taken");
      checkOutput("jumpz_taken pc", pcA, 8'h10);

      // R negative: JUMPZ falls through, JUMPN taken.
      setupTest(8'h80, 0, 0, 5, 10);
      rom[0] = 8'h90; rom[1] = 8'h10; rom[2] = 8'hA0; rom[3] = 8'h20;
      applyStimulus("jumpn");
      checkOutput("jumpz_not_taken pc", pcA, 8'h02);
      checkOutput("jumpn_taken pc", pcB, 8'h20);

      // BUMP+ 3: MEMRD cycle drives every write path at once.
      setupTest(8'h00, 0, 0, 5, 6);
      rom[0] = 8'h60; rom[1] = 8'h03;
      applyStimulus("bump");
      checkOutput("bump memrd outputs", {5'd0, vecA},
                  {5'd0, 8'h02, 8'h03, 2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 4'b0000});
      checkOutput("bump next fetch pc", pcB, 8'h02);

      // Memory/ALU mix ending in an unconditional JUMP to a HALT.
      setupTest(8'h00, 0, 0, -1, -1);
      rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'h40; rom[3] = 8'h06;
      rom[4] = 8'h50; rom[5] = 8'h07; rom[6] = 8'h30; rom[7] = 8'h08;
      rom[8] = 8'h70; rom[9] = 8'h09; rom[10] = 8'h80; rom[11] = 8'h0E;
      applyStimulus("alu_mix");
      checkOutput("alu_mix wR count", wRCount, 4);
      checkOutput("alu_mix wM count", wMCount, 2);

      // JUMP to 0xFF, whose operand byte wraps to address 0.
      setupTest(8'h00, 0, 0, 7, 10);
      rom[0] = 8'h80; rom[1] = 8'hFF; rom[255] = 8'h90;
      applyStimulus("pc_wrap");
      checkOutput("pc_wrap operand fetch pc", pcA, 8'h00);
      checkOutput("pc_wrap jump target pc", pcB, 8'h80);

      // Illegal opcode halts with oIllegal and never writes.
      setupTest(8'h00, 0, 0, -1, -1);
      rom[0] = 8'hC0;
      applyStimulus("illegal");
      checkOutput("illegal halt cycle", haltCycle, 3);
      checkOutput("illegal writes", wRCount + wMCount, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #4 checkOutput("illegal cleared by rst", {oHalt, oIllegal}, 2'b00);

      // Reset arriving while OUTBOX waits on a full FIFO.
      setupTest(8'h00, 0, 0, -1, -1);
      rom[0] = 8'h10;
      doReset();
      iOutFull = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      iOutFull = 1'b0;
      rst      = 1'b1;
      #4 checkOutput("wait_out rst push", oOutPush, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      #4 checkOutput("wait_out rst outputs", {5'd0, dutVec}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
